mem_port_arbiter: RTL and testbench

- Shares the single 8-bit, 13-bit-address program/data memory between two requesters: the instruction-fetch unit (read only) and the data-access unit (LDA/STA/ADA-style read or write).
- Arbitrates round-robin on conflict, drives the memory's address, mem_read, mem_write and write_data lines, and captures read data after a configurable latency.
- Returns a one-cycle done pulse to the granted requester.
- Sits between the CPU controller/datapath and the memory.

---
 rtl/mem_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 523 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one program/data memory between the instruction-fetch port (read
// only) and the data-access port (read or write). Conflicts are resolved
// round-robin. Read data is captured after RD_LAT cycles of mem_read, and
// each finished transaction returns a one-cycle done pulse to its port.
// Optional feature macro: MEM_ARB_BURST_EN (two-byte fetch bursts).
module mem_port_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  if_burst,
    output logic                  if_done,
    output logic [2*DATA_W-1:0]   if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_done,
    output logic [DATA_W-1:0]     d_rdata,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_CAPTURE,
        ST_ACCESS2,
        ST_CAPTURE2
    } state_t;

    typedef enum logic {
        PORT_FETCH,
        PORT_DATA
    } port_t;

    // Final value of the read-latency counter; RD_LAT is legal in 1..7.
    localparam logic [2:0] LAST_CNT = 3'(RD_LAT - 1);

    state_t      state, state_n;
    port_t       grant, grant_n;
    port_t       last_grant, last_grant_n;
    logic [2:0]  cnt, cnt_n;
    logic        is_write;
    logic        is_burst;
    logic        start;
    logic        cap_lo;
    logic        cap_hi;
    logic        addr_inc;
    logic        burst_sel;

`ifdef MEM_ARB_BURST_EN
    assign burst_sel = if_burst;
`else
    // Bursts are not built in; the request flag is deliberately left unused.
    logic burst_unused;
    assign burst_unused = if_burst;
    assign burst_sel    = 1'b0;
`endif

    // State, grant owner, round-robin history and latency counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            grant      <= PORT_FETCH;
            last_grant <= PORT_DATA;
            cnt        <= '0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            last_grant <= last_grant_n;
            cnt        <= cnt_n;
        end
    end

    // Next-state logic: arbitration in IDLE, latency counting in ACCESS.
    always_comb begin
        state_n      = state;
        grant_n      = grant;
        last_grant_n = last_grant;
        cnt_n        = cnt;
        start        = 1'b0;
        cap_lo       = 1'b0;
        cap_hi       = 1'b0;
        addr_inc     = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (if_req || d_req) begin
                    start   = 1'b1;
                    state_n = ST_ACCESS;
                    if (if_req && d_req) begin
                        grant_n = (last_grant == PORT_DATA) ? PORT_FETCH : PORT_DATA;
                    end else if (if_req) begin
                        grant_n = PORT_FETCH;
                    end else begin
                        grant_n = PORT_DATA;
                    end
                    last_grant_n = grant_n;
                end
            end
            ST_ACCESS: begin
                if (is_write) begin
                    state_n = ST_CAPTURE;
                end else if (cnt == LAST_CNT) begin
                    cap_lo  = 1'b1;
                    state_n = ST_CAPTURE;
                end else begin
                    cnt_n = cnt + 3'd1;
                end
            end
            ST_CAPTURE: begin
                cnt_n = '0;
                if (is_burst) begin
                    addr_inc = 1'b1;
                    state_n  = ST_ACCESS2;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ACCESS2: begin
                if (cnt == LAST_CNT) begin
                    cap_hi  = 1'b1;
                    state_n = ST_CAPTURE2;
                end else begin
                    cnt_n = cnt + 3'd1;
                end
            end
            ST_CAPTURE2: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Memory command registers and per-port read data capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            is_write  <= 1'b0;
            is_burst  <= 1'b0;
        end else begin
            if (start) begin
                is_write <= (grant_n == PORT_DATA) && d_we;
                is_burst <= (grant_n == PORT_FETCH) && burst_sel;
                mem_addr <= (grant_n == PORT_FETCH) ? if_addr : d_addr;
                if ((grant_n == PORT_DATA) && d_we) begin
                    mem_wdata <= d_wdata;
                end
            end
            if (addr_inc) begin
                mem_addr <= mem_addr + ADDR_W'(1);
            end
            if (cap_lo) begin
                if (grant == PORT_FETCH) begin
                    if_rdata <= {{DATA_W{1'b0}}, mem_rdata};
                end else begin
                    d_rdata <= mem_rdata;
                end
            end
            if (cap_hi) begin
                if_rdata[2*DATA_W-1:DATA_W] <= mem_rdata;
            end
        end
    end

    assign mem_read  = ((state == ST_ACCESS) && !is_write) || (state == ST_ACCESS2);
    assign mem_write = (state == ST_ACCESS) && is_write;
    assign if_done   = ((state == ST_CAPTURE) && (grant == PORT_FETCH) && !is_burst)
                       || (state == ST_CAPTURE2);
    assign d_done    = (state == ST_CAPTURE) && (grant == PORT_DATA);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter. Instance A uses RD_LAT = 1,
// instance B uses RD_LAT = 3. Expected results come from a transaction-level
// model: a byte array mirroring memory plus the round-robin rule.
// Burst scenario is compiled only with MEM_ARB_BURST_EN.
module tb_mem_port_arbiter;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    // Instance A signals
    logic        if_req, if_burst, if_done, d_req, d_we, d_done;
    logic [12:0] if_addr, d_addr, mem_addr;
    logic [15:0] if_rdata;
    logic [7:0]  d_wdata, d_rdata, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    // Instance B signals
    logic        b_if_req, b_if_burst, b_if_done, b_d_req, b_d_we, b_d_done;
    logic [12:0] b_if_addr, b_d_addr, b_mem_addr;
    logic [15:0] b_if_rdata;
    logic [7:0]  b_d_wdata, b_d_rdata, b_mem_wdata, b_mem_rdata;
    logic        b_mem_read, b_mem_write;

    // Physical memories and the reference image of memory A
    logic [7:0] mem_a     [0:8191];
    logic [7:0] mem_b     [0:8191];
    logic [7:0] model_mem [0:8191];

    // Reference state: expected held read data and last granted port
    logic [15:0] exp_if_rdata;
    logic [7:0]  exp_d_rdata;
    bit          model_last_data;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.ADDR_W(13), .DATA_W(8), .RD_LAT(LAT_A)) dut_a (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_burst(if_burst),
        .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(13), .DATA_W(8), .RD_LAT(LAT_B)) dut_b (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_burst(b_if_burst),
        .if_done(b_if_done), .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_done(b_d_done), .d_rdata(b_d_rdata),
        .mem_addr(b_mem_addr), .mem_read(b_mem_read), .mem_write(b_mem_write),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // Memories answer reads combinationally and take writes on the clock edge
    assign mem_rdata   = mem_a[mem_addr];
    assign b_mem_rdata = mem_b[b_mem_addr];

    always @(posedge clk) begin
        if (mem_write) mem_a[mem_addr] <= mem_wdata;
        if (b_mem_write) mem_b[b_mem_addr] <= b_mem_wdata;
    end

    // Read and write strobes must never be active together on either instance
    always @(negedge clk) begin
        if (rst) begin
            n_checks++;
            if ((mem_read && mem_write) || (b_mem_read && b_mem_write)) begin
                n_fail++;
                $display("[TB] FAIL strobe_overlap: a=%b%b b=%b%b required no overlap",
                         mem_read, mem_write, b_mem_read, b_mem_write);
            end
        end
    end

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        if_req = 0; if_burst = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        b_if_req = 0; b_if_burst = 0; b_if_addr = '0; b_d_req = 0; b_d_we = 0;
        b_d_addr = '0; b_d_wdata = '0;
        for (int i = 0; i < 8192; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            mem_a[i] = v;
            mem_b[i] = v;
            model_mem[i] = v;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) tick();
        n_checks++;
        if ({mem_read, mem_write, mem_addr, mem_wdata} !== 23'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_mem_bus: got %h required 0", {mem_read, mem_write, mem_addr, mem_wdata});
        end
        n_checks++;
        if ({if_done, d_done} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL reset_done: got %b required 00", {if_done, d_done});
        end
        n_checks++;
        if (if_rdata !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL reset_if_rdata: got %h required 0000", if_rdata);
        end
        n_checks++;
        if (d_rdata !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL reset_d_rdata: got %h required 00", d_rdata);
        end
        exp_if_rdata = '0;
        exp_d_rdata = '0;
        model_last_data = 1'b1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single_fetch();
        int done_k = 0;
        int n_reads = 0;
        int n_dones = 0;
        int n_ddone = 0;
        bit addr_ok = 1'b1;
        mem_a[0] = 8'hE7;
        model_mem[0] = 8'hE7;
        @(negedge clk);
        if_addr = 13'd0; if_burst = 1'b0; if_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (mem_read) begin
                n_reads++;
                if (mem_addr !== 13'd0) addr_ok = 1'b0;
            end
            if (d_done) n_ddone++;
            if (if_done) begin
                n_dones++;
                if (done_k == 0) done_k = k;
                if_req = 1'b0;
            end
        end
        exp_if_rdata = {8'h00, model_mem[0]};
        model_last_data = 1'b0;
        n_checks++;
        if (n_reads != LAT_A) begin
            n_fail++;
            $display("[TB] FAIL fetch_read_cycles: got %0d required %0d", n_reads, LAT_A);
        end
        n_checks++;
        if (!addr_ok) begin
            n_fail++;
            $display("[TB] FAIL fetch_addr: got wrong address required 0");
        end
        n_checks++;
        if (done_k != LAT_A + 1 || n_dones != 1 || n_ddone != 0) begin
            n_fail++;
            $display("[TB] FAIL fetch_done: got edge %0d pulses %0d/%0d required edge %0d pulses 1/0",
                     done_k, n_dones, n_ddone, LAT_A + 1);
        end
        n_checks++;
        if (if_rdata !== exp_if_rdata) begin
            n_fail++;
            $display("[TB] FAIL fetch_rdata: got %h required %h", if_rdata, exp_if_rdata);
        end
    endtask

    task automatic test_write_read();
        int done_k = 0;
        int n_writes = 0;
        int n_reads = 0;
        bit bus_ok = 1'b1;
        tick();
        @(negedge clk);
        d_we = 1'b1; d_addr = 13'd255; d_wdata = 8'h07; d_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (mem_read) n_reads++;
            if (mem_write) begin
                n_writes++;
                if (mem_addr !== 13'd255 || mem_wdata !== 8'h07) bus_ok = 1'b0;
            end
            if (d_done) begin
                if (done_k == 0) done_k = k;
                d_req = 1'b0;
            end
        end
        model_mem[255] = 8'h07;
        model_last_data = 1'b1;
        n_checks++;
        if (n_writes != 1 || n_reads != 0 || !bus_ok) begin
            n_fail++;
            $display("[TB] FAIL write_strobe: got writes %0d reads %0d bus_ok %0b required 1 0 1",
                     n_writes, n_reads, bus_ok);
        end
        n_checks++;
        if (done_k != 2) begin
            n_fail++;
            $display("[TB] FAIL write_latency: got edge %0d required 2", done_k);
        end
        n_checks++;
        if (d_rdata !== exp_d_rdata) begin
            n_fail++;
            $display("[TB] FAIL write_keeps_rdata: got %h required %h", d_rdata, exp_d_rdata);
        end
        done_k = 0;
        @(negedge clk);
        d_we = 1'b0; d_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (d_done) begin
                if (done_k == 0) done_k = k;
                d_req = 1'b0;
            end
        end
        exp_d_rdata = model_mem[255];
        n_checks++;
        if (done_k != LAT_A + 1 || d_rdata !== exp_d_rdata) begin
            n_fail++;
            $display("[TB] FAIL read_back: got edge %0d data %h required edge %0d data %h",
                     done_k, d_rdata, LAT_A + 1, exp_d_rdata);
        end
    endtask

    task automatic test_contention();
        int n_done = 0;
        bit port_data;
        bit exp_data_port;
        int exp_k;
        tick();
        @(negedge clk);
        if_addr = 13'd16; d_addr = 13'd32; d_we = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (if_done || d_done) begin
                port_data = d_done;
                exp_data_port = (n_done % 2 == 0) ? !model_last_data : model_last_data;
                exp_k = (LAT_A + 1) + n_done * (LAT_A + 2);
                n_checks++;
                if ((if_done && d_done) || port_data != exp_data_port || k != exp_k) begin
                    n_fail++;
                    $display("[TB] FAIL contention_order: grant %0d got port %0b edge %0d required port %0b edge %0d",
                             n_done, port_data, k, exp_data_port, exp_k);
                end
                n_checks++;
                if (port_data ? (d_rdata !== model_mem[32]) : (if_rdata !== {8'h00, model_mem[16]})) begin
                    n_fail++;
                    $display("[TB] FAIL contention_data: grant %0d got %h/%h required %h/%h",
                             n_done, if_rdata, d_rdata, {8'h00, model_mem[16]}, model_mem[32]);
                end
                n_done++;
                if (n_done == 4) begin
                    if_req = 1'b0;
                    d_req = 1'b0;
                    model_last_data = port_data;
                end
            end
        end
        if_req = 1'b0;
        d_req = 1'b0;
        exp_if_rdata = {8'h00, model_mem[16]};
        exp_d_rdata = model_mem[32];
        n_checks++;
        if (n_done != 4) begin
            n_fail++;
            $display("[TB] FAIL contention_count: got %0d dones required 4", n_done);
        end
    endtask

    task automatic test_rd_lat3();
        int done_k = 0;
        int n_reads = 0;
        bit addr_ok = 1'b1;
        mem_b[127] = 8'h07;
        tick();
        @(negedge clk);
        b_d_we = 1'b0; b_d_addr = 13'd127; b_d_req = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (b_mem_read) begin
                n_reads++;
                if (b_mem_addr !== 13'd127) addr_ok = 1'b0;
            end
            if (b_d_done) begin
                if (done_k == 0) done_k = k;
                b_d_req = 1'b0;
            end
        end
        n_checks++;
        if (n_reads != LAT_B || !addr_ok) begin
            n_fail++;
            $display("[TB] FAIL lat3_read_cycles: got %0d addr_ok %0b required %0d 1", n_reads, addr_ok, LAT_B);
        end
        n_checks++;
        if (done_k != LAT_B + 1) begin
            n_fail++;
            $display("[TB] FAIL lat3_done: got edge %0d required %0d", done_k, LAT_B + 1);
        end
        n_checks++;
        if (b_d_rdata !== 8'h07) begin
            n_fail++;
            $display("[TB] FAIL lat3_rdata: got %h required 07", b_d_rdata);
        end
    endtask

    task automatic test_reset_in_access();
        int done_k = 0;
        int n_early = 0;
        tick();
        @(negedge clk);
        if_addr = 13'd300; if_burst = 1'b0; if_req = 1'b1;
        tick();
        n_checks++;
        if (mem_read !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midreset_access: got mem_read %b required 1", mem_read);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({mem_read, mem_write, mem_addr, mem_wdata, if_done, d_done} !== 25'd0
            || if_rdata !== 16'h0 || d_rdata !== 8'h0) begin
            n_fail++;
            $display("[TB] FAIL midreset_outputs: got bus %h rdata %h/%h required all 0",
                     {mem_read, mem_write, mem_addr, mem_wdata, if_done, d_done}, if_rdata, d_rdata);
        end
        exp_if_rdata = '0;
        exp_d_rdata = '0;
        model_last_data = 1'b1;
        repeat (2) begin
            tick();
            if (if_done || d_done) n_early++;
        end
        n_checks++;
        if (n_early != 0) begin
            n_fail++;
            $display("[TB] FAIL midreset_no_done: got %0d pulses required 0", n_early);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (if_done) begin
                if (done_k == 0) done_k = k;
                if_req = 1'b0;
            end
        end
        exp_if_rdata = {8'h00, model_mem[300]};
        model_last_data = 1'b0;
        n_checks++;
        if (done_k != LAT_A + 1 || if_rdata !== exp_if_rdata) begin
            n_fail++;
            $display("[TB] FAIL midreset_recover: got edge %0d data %h required edge %0d data %h",
                     done_k, if_rdata, LAT_A + 1, exp_if_rdata);
        end
    endtask

    task automatic test_random();
        for (int e = 0; e < 40; e++) begin
            int mode, cyc, exp_kf, exp_kd, kf, kd;
            bit use_f, use_d, we, first_data, p;
            logic [12:0] fa, da;
            logic [7:0] wd;
            mode = int'($urandom_range(1, 3));
            use_f = (mode != 2);
            use_d = (mode != 1);
            fa = 13'($urandom);
            da = ($urandom_range(0, 3) == 0) ? fa : 13'($urandom);
            we = 1'($urandom);
            wd = 8'($urandom);
            first_data = (use_f && use_d) ? !model_last_data : use_d;
            cyc = 0; exp_kf = 0; exp_kd = 0; kf = 0; kd = 0;
            for (int s = 0; s < 2; s++) begin
                p = (s == 0) ? first_data : !first_data;
                if (p && use_d) begin
                    cyc += we ? 3 : LAT_A + 2;
                    exp_kd = cyc - 1;
                    if (we) model_mem[da] = wd;
                    else exp_d_rdata = model_mem[da];
                    model_last_data = 1'b1;
                end else if (!p && use_f) begin
                    cyc += LAT_A + 2;
                    exp_kf = cyc - 1;
                    exp_if_rdata = {8'h00, model_mem[fa]};
                    model_last_data = 1'b0;
                end
            end
            repeat (1 + $urandom_range(0, 2)) tick();
            @(negedge clk);
            if_addr = fa; if_burst = 1'b0; d_addr = da; d_we = we; d_wdata = wd;
            if_req = use_f; d_req = use_d;
            for (int k = 1; k <= 30; k++) begin
                tick();
                if (if_done) begin
                    n_checks++;
                    if (!use_f || kf != 0 || k != exp_kf || if_rdata !== exp_if_rdata) begin
                        n_fail++;
                        $display("[TB] FAIL random_fetch: ep %0d got edge %0d data %h required edge %0d data %h",
                                 e, k, if_rdata, exp_kf, exp_if_rdata);
                    end
                    kf = k;
                    if_req = 1'b0;
                end
                if (d_done) begin
                    n_checks++;
                    if (!use_d || kd != 0 || k != exp_kd || d_rdata !== exp_d_rdata) begin
                        n_fail++;
                        $display("[TB] FAIL random_data: ep %0d got edge %0d data %h required edge %0d data %h",
                                 e, k, d_rdata, exp_kd, exp_d_rdata);
                    end
                    kd = k;
                    d_req = 1'b0;
                end
                if ((!use_f || kf != 0) && (!use_d || kd != 0)) break;
            end
            if_req = 1'b0;
            d_req = 1'b0;
            n_checks++;
            if ((use_f && kf == 0) || (use_d && kd == 0)) begin
                n_fail++;
                $display("[TB] FAIL random_timeout: ep %0d got dones %0d/%0d required %0d/%0d",
                         e, kf, kd, exp_kf, exp_kd);
            end
        end
    endtask

`ifdef MEM_ARB_BURST_EN
    task automatic test_burst();
        int kf = 0;
        int kd = 0;
        int n_if = 0;
        int rd_hi = 0;
        int rd_lo = 0;
        int rd_other = 0;
        logic [15:0] exp_burst;
        mem_a[8191] = 8'hC0; model_mem[8191] = 8'hC0;
        mem_a[0] = 8'h0A; model_mem[0] = 8'h0A;
        exp_burst = {model_mem[0], model_mem[8191]};
        tick();
        @(negedge clk);
        if_addr = 13'd8191; if_burst = 1'b1; if_req = 1'b1;
        d_addr = 13'd100; d_we = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) d_req = 1'b1;
            if (mem_read) begin
                if (mem_addr === 13'd8191 && kf == 0 && rd_lo == 0) rd_hi++;
                else if (mem_addr === 13'd0 && kf == 0) rd_lo++;
                else if (kf == 0) rd_other++;
            end
            if (if_done) begin
                n_if++;
                if (kf == 0) kf = k;
                if_req = 1'b0;
                if_burst = 1'b0;
            end
            if (d_done) begin
                if (kd == 0) kd = k;
                d_req = 1'b0;
            end
        end
        exp_if_rdata = exp_burst;
        exp_d_rdata = model_mem[100];
        model_last_data = 1'b1;
        n_checks++;
        if (rd_hi != LAT_A || rd_lo != LAT_A || rd_other != 0) begin
            n_fail++;
            $display("[TB] FAIL burst_reads: got %0d/%0d/%0d required %0d/%0d/0", rd_hi, rd_lo, rd_other, LAT_A, LAT_A);
        end
        n_checks++;
        if (n_if != 1 || kf != 2 * LAT_A + 2 || if_rdata !== exp_burst) begin
            n_fail++;
            $display("[TB] FAIL burst_done: got pulses %0d edge %0d data %h required 1 %0d %h",
                     n_if, kf, if_rdata, 2 * LAT_A + 2, exp_burst);
        end
        n_checks++;
        if (kd != kf + LAT_A + 2 || d_rdata !== exp_d_rdata) begin
            n_fail++;
            $display("[TB] FAIL burst_data_wait: got edge %0d data %h required %0d %h",
                     kd, d_rdata, kf + LAT_A + 2, exp_d_rdata);
        end
    endtask
`endif

    // Bound the whole run so a stuck design still ends with a report
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus();
        test_reset();
        test_single_fetch();
        test_write_read();
        test_contention();
        test_rd_lat3();
        test_reset_in_access();
        test_random();
`ifdef MEM_ARB_BURST_EN
        test_burst();
`endif
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
